// File: rtl/vga_read_scheduler_pkg.sv
// Shared VGA scan-out constants: default frame geometry, FIFO sizing, burst length
// and the read-scheduler state encoding.
package vga_read_scheduler_pkg;

   localparam int unsigned VGA_FRAME_BYTES = 307200;  // 640x480 at 8 bpp
   localparam int unsigned VGA_FIFO_DEPTH  = 2048;
   localparam int unsigned VGA_BURST_LEN   = 64;

   typedef logic [1:0] vga_state_t;

   localparam vga_state_t StIdle  = 2'd0;
   localparam vga_state_t StCheck = 2'd1;
   localparam vga_state_t StIssue = 2'd2;
   localparam vga_state_t StDone  = 2'd3;

endpackage

// File: rtl/vga_read_scheduler_if.sv
// Avalon-MM read-master bundle between the scan-out scheduler and the memory fabric.
interface vga_read_scheduler_if;

   logic [31:0] master_address;
   logic        master_read;
   logic        master_byteenable;
   logic        master_waitrequest;
   logic        master_readdatavalid;

   modport master (
      output master_address,
      output master_read,
      output master_byteenable,
      input  master_waitrequest,
      input  master_readdatavalid
   );

   modport slave (
      input  master_address,
      input  master_read,
      input  master_byteenable,
      output master_waitrequest,
      output master_readdatavalid
   );

endinterface

// File: rtl/vga_outstanding_ctr.sv
// Tracks reads issued but not yet returned, plus how many of those belong to an
// abandoned frame and must be dropped instead of written to the pixel FIFO.
module vga_outstanding_ctr #(
   parameter int unsigned MAX_COUNT = 2048,
   localparam int unsigned W        = $clog2(MAX_COUNT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,      // read accepted by the slave
   input  logic         dec,      // read data returned
   input  logic         capture,  // frame restart: everything in flight becomes stale
   output logic [W-1:0] count,
   output logic [W-1:0] discard
);

   logic [W-1:0] count_q, count_d;
   logic [W-1:0] discard_q, discard_d;

   // Next-state for both counters; saturating so they can never wrap.
   always_comb begin
      count_d   = count_q;
      discard_d = discard_q;
      if (inc && !dec && count_q != W'(MAX_COUNT)) begin
         count_d = count_q + W'(1);
      end else if (dec && !inc && count_q != '0) begin
         count_d = count_q - W'(1);
      end
      // Capture the post-update count so a same-cycle accept is also discarded.
      if (capture) begin
         discard_d = count_d;
      end else if (dec && discard_q != '0) begin
         discard_d = discard_q - W'(1);
      end
   end

   // Counter state with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         discard_q <= '0;
      end else begin
         count_q   <= count_d;
         discard_q <= discard_d;
      end
   end

   assign count   = count_q;
   assign discard = discard_q;

endmodule

// File: rtl/vga_read_scheduler.sv
// Frame-buffer read scheduler: issues Avalon-MM bursts to keep the pixel FIFO fed,
// restarts cleanly on a new frame_start and drops data from abandoned frames.
module vga_read_scheduler
   import vga_read_scheduler_pkg::*;
#(
   parameter int unsigned FRAME_BYTES = VGA_FRAME_BYTES,
   parameter int unsigned FIFO_DEPTH  = VGA_FIFO_DEPTH,
   parameter int unsigned BURST_LEN   = VGA_BURST_LEN
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [31:0]                 base_addr,
   input  logic                        frame_start,
   input  logic [11:0]                 fifo_used,
   vga_read_scheduler_if.master        avm,
   output logic                        fifo_wrreq,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int unsigned RW = $clog2(FRAME_BYTES + 1);
   localparam int unsigned BW = $clog2(BURST_LEN + 1);
   localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

   vga_state_t    state_q, state_d;
   logic [31:0]   ptr_q, ptr_d;
   logic [RW-1:0] remaining_q, remaining_d;
   logic [BW-1:0] burst_q, burst_d;
   logic          pend_q, pend_d;      // restart requested while a read was stalled
   logic          read_q;
   logic          busy_q;
   logic          done_q;

   logic          accept;
   logic          stalled;
   logic          capture;
   logic          room_ok;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] discard;

   assign accept  = read_q && !avm.master_waitrequest;
   assign stalled = read_q && avm.master_waitrequest;

   // Only start a burst if every byte already buffered or in flight still fits.
   assign room_ok = (32'(fifo_used) + 32'(outstanding) + BURST_LEN) <= FIFO_DEPTH;

   // Next-state: accept bookkeeping first, then enable-drop / restart overrides.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      burst_d     = burst_q;
      pend_d      = pend_q;
      capture     = 1'b0;

      if (accept) begin
         ptr_d       = ptr_q + 32'd1;
         remaining_d = remaining_q - RW'(1);
         burst_d     = burst_q - BW'(1);
      end

      if (state_q != StIdle && stalled && frame_start) begin
         pend_d = 1'b1;
      end

      if (state_q != StIdle && !stalled && !enable) begin
         state_d = StIdle;
         pend_d  = 1'b0;
      end else if (state_q != StIdle && !stalled && (frame_start || pend_q)) begin
         state_d     = StCheck;
         ptr_d       = base_addr;
         remaining_d = RW'(FRAME_BYTES);
         burst_d     = '0;
         pend_d      = 1'b0;
         capture     = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (frame_start && enable) begin
                  state_d     = StCheck;
                  ptr_d       = base_addr;
                  remaining_d = RW'(FRAME_BYTES);
               end
            end
            StCheck: begin
               if (remaining_q == '0) begin
                  state_d = StDone;
               end else if (room_ok) begin
                  state_d = StIssue;
                  burst_d = (32'(remaining_q) >= BURST_LEN) ? BW'(BURST_LEN)
                                                            : BW'(remaining_q);
               end
            end
            StIssue: begin
               if (accept && burst_q == BW'(1)) begin
                  state_d = StCheck;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // FSM state and registered outputs derived from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         remaining_q <= '0;
         burst_q     <= '0;
         pend_q      <= 1'b0;
         read_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         burst_q     <= burst_d;
         pend_q      <= pend_d;
         read_q      <= (state_d == StIssue);
         busy_q      <= (state_d != StIdle);
         done_q      <= (state_d == StDone);
      end
   end

   vga_outstanding_ctr #(
      .MAX_COUNT (FIFO_DEPTH)
   ) u_ctr (
      .clk     (clk),
      .reset   (reset),
      .inc     (accept),
      .dec     (avm.master_readdatavalid),
      .capture (capture),
      .count   (outstanding),
      .discard (discard)
   );

   // ptr only moves on accept or restart, so the address is stable during a stall.
   assign avm.master_address    = ptr_q;
   assign avm.master_read       = read_q;
   assign avm.master_byteenable = 1'b1;

   assign fifo_wrreq = avm.master_readdatavalid && (discard == '0) && !reset;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_vga_read_scheduler.sv
// Directed bench for the VGA read scheduler with a 100-byte frame so that both a
// full 64-read burst and a 36-read tail burst appear in one frame.
module tb_vga_read_scheduler;

   localparam int unsigned FB = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] base_addr;
   logic        frame_start;
   logic [11:0] fifo_used;
   logic        fifo_wrreq;
   logic        busy;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   vga_read_scheduler_if bus ();

   vga_read_scheduler #(
      .FRAME_BYTES (FB),
      .FIFO_DEPTH  (2048),
      .BURST_LEN   (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .base_addr   (base_addr),
      .frame_start (frame_start),
      .fifo_used   (fifo_used),
      .avm         (bus),
      .fifo_wrreq  (fifo_wrreq),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] b);
      base_addr   = b;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // n single-cycle read returns, checking the FIFO write strobe on each.
   task automatic ret(input int n, input logic exp_wr, input string tag);
      for (int i = 0; i < n; i++) begin
         bus.master_readdatavalid = 1'b1;
         #1;
         check(tag, 32'(fifo_wrreq), 32'(exp_wr));
         tick();
      end
      bus.master_readdatavalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] b;
      reset                    = 1'b1;
      enable                   = 1'b1;
      frame_start              = 1'b0;
      base_addr                = '0;
      fifo_used                = '0;
      bus.master_waitrequest   = 1'b0;
      bus.master_readdatavalid = 1'b1;
      tick();
      tick();
      check("rst_read", 32'(bus.master_read), 0);
      check("rst_addr", bus.master_address, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_wrreq", 32'(fifo_wrreq), 0);
      check("rst_outst", 32'(dut.outstanding), 0);
      check("byteenable", 32'(bus.master_byteenable), 1);
      bus.master_readdatavalid = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_read", 32'(bus.master_read), 0);

      // Fill from empty, with the address wrapping through 2^32.
      b = 32'hFFFF_FFE0;
      pulse_start(b);
      check("chk_busy", 32'(busy), 1);
      check("chk_read", 32'(bus.master_read), 0);
      tick();
      for (int i = 0; i < 64; i++) begin
         check("fill_read", 32'(bus.master_read), 1);
         check("fill_addr", bus.master_address, b + 32'(i));
         tick();
      end
      check("gap_read", 32'(bus.master_read), 0);
      check("gap_addr", bus.master_address, b + 32'd64);
      tick();
      for (int i = 0; i < 36; i++) begin
         check("tail_read", 32'(bus.master_read), 1);
         check("tail_addr", bus.master_address, b + 32'd64 + 32'(i));
         tick();
      end
      check("eof_read", 32'(bus.master_read), 0);
      check("eof_done_early", 32'(frame_done), 0);
      tick();
      check("eof_done_pulse", 32'(frame_done), 1);
      check("eof_busy", 32'(busy), 1);
      tick();
      check("eof_done_clear", 32'(frame_done), 0);
      check("eof_idle_busy", 32'(busy), 0);
      check("eof_idle_read", 32'(bus.master_read), 0);
      check("outst_100", 32'(dut.outstanding), 100);
      ret(100, 1'b1, "fill_wr");
      check("outst_0", 32'(dut.outstanding), 0);

      // FIFO backpressure, stall and simultaneous accept/return.
      b = 32'h0000_1000;
      fifo_used = 12'd1985;
      pulse_start(b);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold", 32'(bus.master_read), 0);
      end
      fifo_used = 12'd1984;
      tick();
      check("bp_go", 32'(bus.master_read), 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_addr", bus.master_address, b + 32'(i));
         tick();
      end
      bus.master_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.master_readdatavalid = 1'b1;
         #1;
         check("stall_read", 32'(bus.master_read), 1);
         check("stall_addr", bus.master_address, b + 32'd10);
         check("stall_wr", 32'(fifo_wrreq), 1);
         tick();
      end
      bus.master_waitrequest = 1'b0;
      for (int i = 10; i < 15; i++) begin
         check("simul_addr", bus.master_address, b + 32'(i));
         tick();
      end
      bus.master_readdatavalid = 1'b0;
      check("simul_outst", 32'(dut.outstanding), 5);
      for (int i = 15; i < 64; i++) begin
         check("post_stall_addr", bus.master_address, b + 32'(i));
         tick();
      end
      check("burst_end_read", 32'(bus.master_read), 0);
      check("burst_end_outst", 32'(dut.outstanding), 54);
      ret(44, 1'b1, "bp_wr");
      check("blocked_outst", 32'(dut.outstanding), 10);
      check("blocked_read", 32'(bus.master_read), 0);

      // Restart with ten reads in flight.
      b = 32'h0000_2000;
      pulse_start(b);
      check("rs_addr", bus.master_address, b);
      check("rs_read", 32'(bus.master_read), 0);
      check("rs_done", 32'(frame_done), 0);
      check("rs_busy", 32'(busy), 1);
      ret(10, 1'b0, "discard_wr");
      check("rs_outst", 32'(dut.outstanding), 0);
      fifo_used = '0;
      tick();
      check("rs_issue_read", 32'(bus.master_read), 1);
      check("rs_issue_addr", bus.master_address, b);
      tick();
      bus.master_readdatavalid = 1'b1;
      #1;
      check("post_discard_wr", 32'(fifo_wrreq), 1);
      tick();
      bus.master_readdatavalid = 1'b0;

      // Reset in the middle of a burst.
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_read", 32'(bus.master_read), 0);
      check("rst_mid_addr", bus.master_address, 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_outst", 32'(dut.outstanding), 0);
      check("rst_mid_rem", 32'(dut.remaining_q), 0);
      check("rst_mid_burst", 32'(dut.burst_q), 0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_read", 32'(bus.master_read), 0);

      // Enable drop while a read is stalled.
      b = 32'h0000_3000;
      pulse_start(b);
      tick();
      bus.master_waitrequest = 1'b1;
      enable = 1'b0;
      tick();
      tick();
      check("en_hold_read", 32'(bus.master_read), 1);
      check("en_hold_addr", bus.master_address, b);
      bus.master_waitrequest = 1'b0;
      tick();
      check("en_idle_read", 32'(bus.master_read), 0);
      check("en_idle_busy", 32'(busy), 0);
      check("en_idle_outst", 32'(dut.outstanding), 1);

      // Restart requested while a read is stalled.
      enable = 1'b1;
      b = 32'h0000_4000;
      pulse_start(b);
      tick();
      bus.master_waitrequest = 1'b1;
      pulse_start(32'h0000_5000);
      check("rs_stall_read", 32'(bus.master_read), 1);
      check("rs_stall_addr", bus.master_address, b);
      tick();
      check("rs_stall_addr2", bus.master_address, b);
      bus.master_waitrequest = 1'b0;
      tick();
      check("rs_after_addr", bus.master_address, 32'h0000_5000);
      check("rs_after_read", 32'(bus.master_read), 0);
      check("rs_after_outst", 32'(dut.outstanding), 2);
      check("rs_after_done", 32'(frame_done), 0);
      tick();
      check("rs_reissue_read", 32'(bus.master_read), 1);
      check("rs_reissue_addr", bus.master_address, 32'h0000_5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_read_scheduler.md
VGA_READ_SCHEDULER -- requirements
Module: vga_read_scheduler

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 307200: bytes fetched per frame (640x480, 8 bpp).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2048: pixel FIFO capacity in bytes.
REQ-003 SHALL have parameter BURST_LEN, default 64: maximum reads per scheduled burst.
REQ-004 SHALL have port clk, input, 1: sole clock. One clock; reset is asynchronous and active-high.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-006 SHALL have port enable, input, 1: scan-out enable from the register block.
REQ-007 SHALL have port base_addr, input, 32: frame buffer byte address.
REQ-008 SHALL have port frame_start, input, 1: single-cycle pulse, already in the clk domain.
REQ-009 SHALL have port fifo_used, input, 12: FIFO write-side fill level.
REQ-010 SHALL have port master_address, output, 32: Avalon-MM read address.
REQ-011 SHALL have port master_read, output, 1: Avalon-MM read request.
REQ-012 SHALL have port master_byteenable, output, 1: constant 1.
REQ-013 SHALL have port master_waitrequest, input, 1: slave stall.
REQ-014 SHALL have port master_readdatavalid, input, 1: read data return.
REQ-015 SHALL have port fifo_wrreq, output, 1: FIFO write strobe.
REQ-016 SHALL have port busy, output, 1: high when not in IDLE.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse when the last frame byte is accepted.

Function
REQ-018 SHALL implement states IDLE, CHECK, ISSUE, DONE, all with registered outputs.
REQ-019 SHALL leave IDLE for CHECK when frame_start=1 and enable=1.
- On leaving IDLE: ptr<=base_addr, remaining<=FRAME_BYTES.
REQ-020 SHALL move CHECK to ISSUE when all of the following hold:
- remaining>0;
- fifo_used+outstanding+BURST_LEN<=FIFO_DEPTH.
- On that transition: burst count<=min(BURST_LEN, remaining).
REQ-021 SHALL go CHECK to DONE when remaining=0; DONE pulses frame_done for one cycle, then returns to IDLE.
REQ-022 SHALL, in ISSUE, drive master_read=1 and master_address=ptr.
- A read is accepted in a cycle with master_waitrequest=0.
- On accept: ptr+1, remaining-1, burst count-1, outstanding+1.
- Accepted reads are back-to-back, one per cycle.
REQ-023 SHALL return from ISSUE to CHECK on the accept that brings the burst count to 0.
- master_read is low in the following cycle.
REQ-024 SHALL hold master_address and master_read stable while master_waitrequest=1.
REQ-025 SHALL decrement outstanding on each master_readdatavalid.
- A simultaneous accept and return leaves outstanding unchanged.
- Counter width is clog2(FIFO_DEPTH+1); it never wraps.
REQ-026 SHALL latch discard<=outstanding on a frame restart.
- While discard>0, returning data decrements discard and fifo_wrreq stays 0.
- Otherwise fifo_wrreq=master_readdatavalid, same cycle, combinational.
REQ-027 SHALL handle frame_start arriving outside IDLE as a restart:
- If no request is stalled: restart at the next edge.
- If a request is stalled: hold the stalled request until accepted, then restart.
- Restart means ptr<=base_addr, remaining<=FRAME_BYTES, state CHECK, and no frame_done.
REQ-028 SHALL handle enable=0 outside IDLE as follows:
- Finish any stalled request.
- Then go to IDLE; outstanding and discard keep tracking returns.
REQ-029 SHALL give remaining a width of clog2(FRAME_BYTES+1).
- ptr arithmetic is 32-bit modulo 2^32.

Reset
REQ-030 SHALL asynchronously force the following while reset=1:
- state IDLE;
- master_read=0, master_address=0;
- fifo_wrreq=0, busy=0, frame_done=0;
- outstanding=0, discard=0, remaining=0, burst count=0.
REQ-031 SHALL, when reset asserts mid-burst, drop master_read immediately; on release, wait for the next frame_start.

Structure
REQ-032 SHALL keep the state encoding and the default FRAME_BYTES, FIFO_DEPTH and BURST_LEN constants in a shared VGA package.
REQ-033 SHALL contain one sub-module, vga_outstanding_ctr: up/down counter with simultaneous inc/dec and a discard capture.

Verification
REQ-034 SHALL cover fill from empty:
- Stimulus: fifo_used=0, waitrequest=0, frame_start pulse.
- Response: 64 consecutive reads at base..base+63, master_read low for 1 cycle, next burst begins.
REQ-035 SHALL cover FIFO backpressure:
- Stimulus: fifo_used=1985, outstanding=0.
- Response: stays in CHECK (1985+64>2048); enters ISSUE when fifo_used drops to 1984.
REQ-036 SHALL cover stall:
- Stimulus: waitrequest=1 for 5 cycles mid-burst.
- Response: address constant, read held; burst completes with exactly 64 accepts.
REQ-037 SHALL cover restart with in-flight reads:
- Stimulus: frame_start while outstanding=10.
- Response: the next 10 readdatavalid produce no fifo_wrreq; ptr reloads to base_addr.
REQ-038 SHALL cover end of frame:
- Stimulus: FRAME_BYTES=100, BURST_LEN=64.
- Response: bursts of 64 then 36; frame_done pulses once; state returns to IDLE.
REQ-039 SHALL cover reset mid-burst:
- Stimulus: reset asserted during ISSUE.
- Response: master_read=0 in the same cycle; all counters 0.
